// File: rtl/seq_shr_pkg.sv
// seq_shr_pkg -- shared definitions for the sequential right shifter.
// Holds the FSM state encoding used by seq_shr and by its testbench.
// The data width is deliberately not defined here; it is a parameter of seq_shr.
package seq_shr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shr.sv
// seq_shr -- sequential right shifter, one bit position per clock.
//
// Accepts an operand and a shift distance through a valid/ready handshake,
// shifts the working register right one bit per edge while a down-counter
// runs to its terminal count, then presents the result until it is taken.
//
// Optional feature macro: SEQ_SHR_ARITH_EN
//   defined   -> adds input 'arith'; arith=1 at accept replicates the
//                operand's MSB into the vacated bits (arithmetic shift)
//   undefined -> logical shifts only, no 'arith' port
//
// Ports:
//   Clk        in   clock, rising edge
//   Rst        in   asynchronous active-high reset
//   a          in   [DATAWIDTH-1:0]         operand
//   sh_amt     in   [clog2(DATAWIDTH)-1:0]  right-shift distance
//   in_valid   in   operand request
//   in_ready   out  block can accept an operand (IDLE)
//   d          out  [DATAWIDTH-1:0] result, valid while out_valid
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   busy       out  operation in progress or result pending
//   arith      in   arithmetic-shift select (SEQ_SHR_ARITH_EN only)
//
// State table:
//   IDLE  | waiting for an operand; in_ready high
//   SHIFT | shifting one bit per edge, counter counting down
//   DONE  | result on d, held until out_ready
module seq_shr
  import seq_shr_pkg::*;
#(
  parameter int DATAWIDTH = 8
)
(
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [DATAWIDTH-1:0]         a,
  input  logic [$clog2(DATAWIDTH)-1:0] sh_amt,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATAWIDTH-1:0]         d,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef SEQ_SHR_ARITH_EN
  input  logic                         arith,
`endif
  output logic                         busy
);

  localparam int CW = $clog2(DATAWIDTH);

  state_t                 state;
  logic [DATAWIDTH-1:0]   work;
  logic [CW-1:0]          cnt;
  logic                   fill;
  logic                   fill_next;

  // Bit shifted into the MSB on every step; fixed at accept so later
  // changes of a/arith cannot disturb an operation in flight.
`ifdef SEQ_SHR_ARITH_EN
  assign fill_next = arith & a[DATAWIDTH-1];
`else
  assign fill_next = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= a;
            cnt   <= sh_amt;
            fill  <= fill_next;
            state <= (sh_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work <= {fill, work[DATAWIDTH-1:1]};
          cnt  <= cnt - CW'(1);
          // Terminal count: this edge performs the last shift.
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode directly from registers; no input-to-output paths.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign d         = work;

endmodule
